// File: rtl/alu_pipe8_pkg.sv
// Shared widths and opcode encodings for the alu_pipe8 pipelined ALU.
// Imported by the core, the interface and the top level.
package alu_pkg;
    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
    localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1010;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1011;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b1100;
    localparam logic [OP_W-1:0] OP_HOLD = 4'b1101;
    localparam logic [OP_W-1:0] OP_ROR  = 4'b1110;
    localparam logic [OP_W-1:0] OP_ROL  = 4'b1111;
endpackage

// File: rtl/alu_pipe8_if.sv
// Signal bundle for driving/observing alu_pipe8; z exists only with ALU_ZERO_FLAG_EN.
// The master side supplies operands and opcode, the slave side returns the result.
interface alu_pipe8_if;
    import alu_pkg::*;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   ctr;
    logic [DATA_W-1:0] o;
`ifdef ALU_ZERO_FLAG_EN
    logic              z;
    modport master (output a, b, ctr, input o, z);
    modport slave  (input a, b, ctr, output o, z);
`else
    modport master (output a, b, ctr, input o);
    modport slave  (input a, b, ctr, output o);
`endif
endinterface

// File: rtl/alu_pipe8_core.sv
// Purely combinational ALU function (op, a, b) -> res; no state.
// Hold and reserved opcodes produce 0 here; the top level handles hold.
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_res
);
    always_comb begin
        o_res = '0;
        case (i_op)
            OP_ADD: o_res = i_a + i_b;
            OP_SUB: o_res = i_a - i_b;
            OP_AND: o_res = i_a & i_b;
            OP_OR:  o_res = i_a | i_b;
            OP_XOR: o_res = i_a ^ i_b;
            OP_NOT: o_res = ~i_a;
            OP_SHR: o_res = {1'b0, i_a[DATA_W-1:1]};
            OP_ROR: o_res = {i_a[0], i_a[DATA_W-1:1]};
            OP_ROL: o_res = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
            default: o_res = '0;
        endcase
    end
endmodule

// File: rtl/alu_pipe8.sv
// Two-stage 8-bit ALU: stage 1 registers A/B/CTR, stage 2 registers the result.
// Optional zero flag output Z is enabled by defining ALU_ZERO_FLAG_EN.
module alu_pipe8
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] O,
    input  logic [OP_W-1:0]   CTR,
    input  logic              ck,
    input  logic              rst_n
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic              Z
`endif
);
    logic [DATA_W-1:0] r_ina;
    logic [DATA_W-1:0] r_inb;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_o;
    logic [DATA_W-1:0] w_res;

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_ina <= '0;
            r_inb <= '0;
            r_op  <= OP_ADD;
        end else begin
            r_ina <= A;
            r_inb <= B;
            r_op  <= CTR;
        end
    end

    alu_core u_core (
        .i_op  (r_op),
        .i_a   (r_ina),
        .i_b   (r_inb),
        .o_res (w_res)
    );

    // A hold op in stage 2 simply skips the write, so O keeps its last value.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_o <= '0;
        end else if (r_op != OP_HOLD) begin
            r_o <= w_res;
        end
    end

    assign O = r_o;

`ifdef ALU_ZERO_FLAG_EN
    logic r_z;

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_z <= 1'b0;
        end else if (r_op != OP_HOLD) begin
            r_z <= (w_res == '0);
        end
    end

    assign Z = r_z;
`endif
endmodule

// File: tb/tb_alu_pipe8.sv
// Self-checking bench for alu_pipe8: directed table, hand-written corner sequences
// and randomized back-to-back ops against an arithmetic reference model.
module tb_alu_pipe8;
    import alu_pkg::*;

    logic ck;
    logic rst_n;
    int   checks;
    int   errors;

    alu_pipe8_if bus ();

    alu_pipe8 dut (
        .A     (bus.a),
        .B     (bus.b),
        .O     (bus.o),
        .CTR   (bus.ctr),
        .ck    (ck),
        .rst_n (rst_n)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .Z     (bus.z)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Reference model state: expected O/Z and the operation sampled on the previous edge.
    logic [7:0] m_o;
    logic       m_z;
    logic [7:0] p_a;
    logic [7:0] p_b;
    logic [3:0] p_op;

    function automatic logic [7:0] ref_res(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        r = 0;
        case (op)
            4'b0000: r = (ia + ib) % 256;
            4'b0001: r = (ia - ib + 256) % 256;
            4'b1000: r = int'(a & b);
            4'b1001: r = int'(a | b);
            4'b1010: r = int'(a ^ b);
            4'b1011: r = 255 - ia;
            4'b1100: r = ia / 2;
            4'b1110: r = ia / 2 + (ia % 2) * 128;
            4'b1111: r = (ia * 2) % 256 + ia / 128;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, step the model across the edge, then compare the model.
    task automatic cyc(input logic r, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [7:0] res;
        rst_n   = r;
        bus.a   = a;
        bus.b   = b;
        bus.ctr = op;
        @(posedge ck);
        #1;
        if (!r) begin
            m_o  = 8'h00;
            m_z  = 1'b0;
            p_a  = 8'h00;
            p_b  = 8'h00;
            p_op = 4'b0000;
        end else begin
            if (p_op != 4'b1101) begin
                res = ref_res(p_op, p_a, p_b);
                m_o = res;
                m_z = (res == 8'h00);
            end
            p_a  = a;
            p_b  = b;
            p_op = op;
        end
        check8("model_o", bus.o, m_o);
`ifdef ALU_ZERO_FLAG_EN
        check8("model_z", {7'd0, bus.z}, {7'd0, m_z});
`endif
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        checks = 0;
        errors = 0;
        m_o = 8'h00; m_z = 1'b0; p_a = 8'h00; p_b = 8'h00; p_op = 4'b0000;

        vecs.push_back('{8'hF0, 8'h20, 4'b0000, 8'h10});
        vecs.push_back('{8'hF0, 8'h20, 4'b0001, 8'hD0});
        vecs.push_back('{8'h00, 8'h01, 4'b0001, 8'hFF});
        vecs.push_back('{8'hFF, 8'h01, 4'b0000, 8'h00});
        vecs.push_back('{8'hCA, 8'h0F, 4'b1000, 8'h0A});
        vecs.push_back('{8'hCA, 8'h0F, 4'b1001, 8'hCF});
        vecs.push_back('{8'hCA, 8'h0F, 4'b1010, 8'hC5});
        vecs.push_back('{8'hCA, 8'h0F, 4'b1011, 8'h35});
        vecs.push_back('{8'h81, 8'h5A, 4'b1100, 8'h40});
        vecs.push_back('{8'h81, 8'h5A, 4'b1110, 8'hC0});
        vecs.push_back('{8'h81, 8'h5A, 4'b1111, 8'h03});
        vecs.push_back('{8'h33, 8'h44, 4'b0010, 8'h00});
        vecs.push_back('{8'h33, 8'h44, 4'b0111, 8'h00});

        // Reset held for two edges, released with 3+4 on the inputs.
        cyc(1'b0, 8'd3, 8'd4, 4'b0000);
        check8("reset_o_1", bus.o, 8'h00);
        cyc(1'b0, 8'd3, 8'd4, 4'b0000);
        check8("reset_o_2", bus.o, 8'h00);
        cyc(1'b1, 8'd3, 8'd4, 4'b0000);
        cyc(1'b1, 8'd3, 8'd4, 4'b0000);
        check8("reset_release", bus.o, 8'h07);

        foreach (vecs[i]) begin
            cyc(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            cyc(1'b1, 8'h00, 8'h00, 4'b0000);
            check8($sformatf("vec%0d", i), bus.o, vecs[i].exp);
        end

        // Hold keeps the previous result, then a reserved op clears it.
        cyc(1'b1, 8'd5, 8'd6, 4'b0000);
        cyc(1'b1, 8'hAA, 8'h55, 4'b1101);
        check8("hold_pre", bus.o, 8'h0B);
        cyc(1'b1, 8'hAA, 8'h55, 4'b0100);
        check8("hold_keep", bus.o, 8'h0B);
        cyc(1'b1, 8'h00, 8'h00, 4'b0000);
        check8("reserved_clr", bus.o, 8'h00);

        // Reset mid-pipeline drops the in-flight op.
        cyc(1'b1, 8'd10, 8'd20, 4'b0000);
        cyc(1'b0, 8'd1, 8'd1, 4'b0000);
        check8("midreset_o", bus.o, 8'h00);
        cyc(1'b1, 8'd9, 8'd9, 4'b0000);
        check8("midreset_flush", bus.o, 8'h00);
        cyc(1'b1, 8'd0, 8'd0, 4'b0000);
        check8("midreset_next", bus.o, 8'h12);

        // Random back-to-back ops, some biased toward zero results.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [3:0] rop;
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            rop = 4'($urandom_range(0, 15));
            cyc(1'b1, ra, rb, rop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
